// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: arbitrates the single-port 16x8 program/data RAM between
// the CPU datapath and the program loader / front panel. Every access is a
// fixed IDLE -> ACCESS -> RESP sequence. The RAM itself samples on the falling
// edge inside ACCESS, so address, data and strobe are stable around that edge.
module ram_access_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ram_rw,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    logic [1:0] state;
    logic       owner;       // requester of the access in flight
    logic       owner_we;    // in-flight access is a write (no rdata update)
    logic       last_grant;  // most recent winner, loses the next tie
    logic       grant_vld;
    logic       grant_sel;

    assign busy = (state != IDLE);

    // Pick a winner from the live requests; only consulted while IDLE.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = OWN_CPU;
        if (prog_mode) begin
            // Loader-only mode: the CPU keeps waiting with its request held.
            if (ldr_req) begin
                grant_vld = 1'b1;
                grant_sel = OWN_LDR;
            end
        end else if (cpu_req && ldr_req) begin
            grant_vld = 1'b1;
            grant_sel = (last_grant == OWN_LDR) ? OWN_CPU : OWN_LDR;
        end else if (cpu_req) begin
            grant_vld = 1'b1;
            grant_sel = OWN_CPU;
        end else if (ldr_req) begin
            grant_vld = 1'b1;
            grant_sel = OWN_LDR;
        end
    end

    // Access sequencer: latch operands at grant, strobe for one cycle, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            owner_we   <= 1'b0;
            last_grant <= OWN_LDR;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    ram_rw <= 1'b0;
                    if (grant_vld) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        if (grant_sel == OWN_LDR) begin
                            ram_addr  <= ldr_addr;
                            ram_wdata <= ldr_wdata;
                            ram_rw    <= ldr_we;
                            owner_we  <= ldr_we;
                        end else begin
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            ram_rw    <= cpu_we;
                            owner_we  <= cpu_we;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM has acted on the falling edge of this cycle;
                    // drop the strobe and capture its read output.
                    ram_rw <= 1'b0;
                    state  <= RESP;
                    if (owner == OWN_LDR) begin
                        ldr_ack <= 1'b1;
                        if (!owner_we) begin
                            ldr_rdata <= ram_rdata;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!owner_we) begin
                            cpu_rdata <= ram_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    ram_rw <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: a negedge-sampling RAM model, a table of single
// transactions, and hand-written sequences for arbitration and reset corners.
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_mode;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [3:0] cpu_addr, ldr_addr;
    logic [7:0] cpu_wdata, ldr_wdata;
    logic       cpu_ack, ldr_ack;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic       ram_rw;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model: samples on the falling edge, registered read port.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
    end
    always @(negedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard of expected acknowledgements, in grant order.
    typedef struct {
        logic       who;    // 0 = CPU, 1 = loader
        logic [7:0] rdata;  // owner's rdata expected alongside the ack
        logic [3:0] addr;   // ram_addr expected (held through RESP)
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       pm;
        logic       who;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic push_exp(input logic who, input logic [7:0] rd, input logic [3:0] a);
        exp_t e;
        e.who = who;
        e.rdata = rd;
        e.addr = a;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the given requester's ack; lat = negedges waited, 0 on timeout.
    task automatic wait_ack(input logic who, output int lat, output int rw_cnt);
        lat = 0;
        rw_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ram_rw) rw_cnt++;
            if (who ? ldr_ack : cpu_ack) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic pm, input logic who, input logic we,
                           input logic [3:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
        int lat, rwc;
        push_exp(who, exp_rd, a);
        @(posedge clk);
        #1;
        prog_mode = pm;
        if (who) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        wait_ack(who, lat, rwc);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        chk("txn_latency", lat, 3);
        chk("txn_rw_pulses", rwc, int'(we));
    endtask

    // Ack monitor and strobe invariants.
    logic prev_rw = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ack || ldr_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", int'({cpu_ack, ldr_ack}), 0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", int'({cpu_ack, ldr_ack}), e.who ? 1 : 2);
                chk("ack_rdata", int'(e.who ? ldr_rdata : cpu_rdata), int'(e.rdata));
                chk("ack_ram_addr", int'(ram_addr), int'(e.addr));
            end
        end
        if (ram_rw) begin
            chk("rw_single_cycle", int'(prev_rw), 0);
            chk("rw_only_when_busy", int'(busy), 1);
        end
        prev_rw = ram_rw;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rwc, n, hi;
        int ack_at[4];

        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'h3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h7, 8'h5A, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4'h7, 8'h11, 8'hA5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 8'h11};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 4'h0, 8'hFF, 8'h11};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hFF};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 4'h7, 8'h00, 8'h11};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 4'h5, 8'hC3, 8'h11};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 4'h6, 8'h99, 8'h11};

        rst = 1'b1; prog_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 4'h0; ldr_wdata = 8'h00;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_rw", int'(ram_rw), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_ldr_ack", int'(ldr_ack), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("rst_ldr_rdata", int'(ldr_rdata), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || ram_rw || cpu_ack || ldr_ack) hi++;
        end
        chk("idle_quiet", hi, 0);

        // Table of single transactions
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].pm, vecs[i].who, vecs[i].we, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Round-robin with both requests held: CPU, LDR, CPU, LDR
        push_exp(1'b0, 8'h00, 4'h1);
        push_exp(1'b1, 8'h11, 4'h2);
        push_exp(1'b0, 8'h00, 4'h1);
        push_exp(1'b1, 8'h11, 4'h2);
        @(posedge clk);
        #1;
        prog_mode = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h2; ldr_wdata = 8'h77;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) begin
                ack_at[n] = k;
                n++;
                if (n == 4) begin
                    cpu_req = 1'b0;
                    ldr_req = 1'b0;
                    break;
                end
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        chk("rr_ack_count", n, 4);
        if (n == 4) begin
            chk("rr_first_latency", ack_at[0], 3);
            for (int j = 1; j < 4; j++) chk("rr_ack_spacing", ack_at[j] - ack_at[j-1], 3);
        end

        // prog_mode lockout of the CPU
        @(posedge clk);
        #1;
        prog_mode = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || ram_rw || busy) hi++;
        end
        chk("lockout_quiet", hi, 0);
        @(posedge clk);
        push_exp(1'b0, 8'hA5, 4'h3);
        #1 prog_mode = 1'b0;
        wait_ack(1'b0, lat, rwc);
        cpu_req = 1'b0;
        chk("lockout_release_latency", lat, 3);

        // Operands latched at grant
        push_exp(1'b0, 8'hC3, 4'h5);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
        @(posedge clk);
        #1 cpu_addr = 4'h6;
        wait_ack(1'b0, lat, rwc);
        cpu_req = 1'b0;
        chk("operand_hold_latency", lat, 2);

        // Reset during ACCESS of a loader write
        @(posedge clk);
        #1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h3C;
        @(posedge clk);
        #1;
        chk("midrst_in_access", int'(busy), 1);
        rst = 1'b1;
        ldr_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ldr_ack", int'(ldr_ack), 0);
        chk("midrst_ram_rw", int'(ram_rw), 0);
        chk("midrst_ram_addr", int'(ram_addr), 0);
        chk("midrst_ram_wdata", int'(ram_wdata), 0);
        chk("midrst_cpu_rdata", int'(cpu_rdata), 0);
        chk("midrst_ldr_rdata", int'(ldr_rdata), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_txn(1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 8'h3C);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sequences and shares the single-port 16x8 program/data RAM between two requesters: the CPU datapath (cpu_*) and the program loader / front panel (ldr_*).
- The controller runs on posedge clk. The RAM samples on negedge clk of the same clock.
- The controller drives RAM address, write strobe and write data from registers. It returns read data with a fixed latency.
- Write strobe is asserted for exactly one cycle per write, so no spurious writes occur.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  system clock; controller logic on posedge.
- rst  in  1  synchronous, active-high reset.
- prog_mode  in  1  1 = loader-only access (CPU stalled); 0 = round-robin sharing.
- cpu_req  in  1  CPU access request; held with operands until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read result; valid with cpu_ack on reads, held until next CPU read.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: same as cpu_* for the loader.
- ram_rw  out  1  to RAM rw.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data_in.
- ram_rdata  in  DATA_WIDTH  from RAM data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0: ram_rw, ram_addr, ram_wdata, cpu_ack, ldr_ack, cpu_rdata, ldr_rdata, busy.
  - State = IDLE.
  - last_grant = LDR, so the first tie goes to the CPU.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: requests are sampled only in this state.
  - prog_mode=1: grant the loader if ldr_req; cpu_req is ignored (CPU waits).
  - prog_mode=0: single requester → grant it. Both requesting → grant the one not equal to last_grant.
  - On grant: latch the granted addr, we and wdata into ram_addr, ram_wdata and ram_rw (ram_rw = we). Record the owner, update last_grant, go to ACCESS.
  - No request: stay in IDLE; ram_rw = 0.
- ACCESS: exactly one cycle.
  - The RAM acts on the negedge inside this cycle.
  - At the closing posedge: ram_rw ← 0 and go to RESP.
  - ram_addr is held through RESP.
- RESP: one cycle.
  - Owner's ack = 1 for this cycle only.
  - On reads, the owner's rdata ← ram_rdata, registered at the ACCESS→RESP posedge so it is valid with ack.
  - On writes, rdata is unchanged.
  - Non-owner's ack stays 0.
  - Next state is IDLE.
- Latency: req seen at posedge N (in IDLE) → ack high during cycle N+2 → next grant possible at posedge N+3. Throughput is one access per 3 cycles.
- Back-to-back: a requester keeping req high after ack is treated as a new request in IDLE. Round-robin still applies.
- prog_mode changes take effect only in IDLE; an in-flight transaction always completes.
- Operands are latched at grant; requester changes after grant have no effect on the in-flight access.
- Reset mid-operation:
  - rst in ACCESS: the negedge write in that cycle has already committed. No ack is issued; all outputs are cleared next cycle.
  - rst in RESP: the ack for that cycle is still visible; everything is cleared at the posedge.
- ram_rw must never be high for two consecutive cycles, and never high outside ACCESS.
- Address wraps naturally at 2**ADDR_WIDTH; no range checking.

Test Plan:
- Reset/idle: assert rst 2 cycles, no requests → all outputs 0, busy=0, ram_rw never high.
- Loader write then CPU read: prog_mode=1, ldr write addr 4'h3 data 8'hA5 → ldr_ack 2 cycles after req, ram_rw high exactly 1 cycle. Then prog_mode=0, cpu read addr 4'h3 → cpu_ack with cpu_rdata=8'hA5.
- Round-robin: prog_mode=0, both requesters hold req (CPU reads addr 1, loader writes addr 2). Grants alternate CPU, LDR, CPU, LDR. Acks arrive every 3 cycles; ram_addr follows 1, 2, 1, 2.
- prog_mode lockout: prog_mode=1, cpu_req held 10 cycles with no ldr_req → no cpu_ack, ram_rw=0, busy=0. Drop prog_mode → cpu_ack 2 cycles after the next IDLE sample.
- Operand stability: CPU read of addr 5 granted; change cpu_addr to 6 during ACCESS → ram_addr stays 5 and returned data is mem[5].
- Reset mid-access: loader write 8'h3C to addr 4'hF, assert rst during ACCESS → no ldr_ack. A later CPU read of 4'hF returns 8'h3C; all outputs are 0 the cycle after reset.
